core_acc_mc: RTL and testbench
==============================

CORE_ACC_MC -- requirements
Module: core_acc_mc

Interface
REQ-001 Parameters SHALL be:
- NUM_CH, default 4, number of independent accumulation lanes.
- IDATA_WIDTH, default 24, signed input width per lane.
- ODATA_WIDTH, default 32, signed accumulator/output width per lane; ODATA_WIDTH >= IDATA_WIDTH.
- CDATA_ACCU_NUM_WIDTH, default 8, width of the group-length config.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock; all logic on its rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- cfg_acc_num  in  CDATA_ACCU_NUM_WIDTH  beats per accumulation group.
- cfg_clr  in  1  synchronous flush of partial sums.
- idata  in  NUM_CH*IDATA_WIDTH  lane k at bits [k*IDATA_WIDTH +: IDATA_WIDTH].
- idata_valid  in  1  input beat offered.
- idata_ready  out  1  input beat can be accepted.
- odata  out  NUM_CH*ODATA_WIDTH  packed per-lane results, same packing rule.
- odata_valid  out  1  result held.
- odata_ready  in  1  downstream accepts result.

Function
REQ-003 A beat SHALL be accepted exactly when idata_valid && idata_ready at a rising clk edge.
REQ-004 Each lane SHALL sign-extend its IDATA_WIDTH input to ODATA_WIDTH before adding it to its own accumulator. Lanes SHALL share one beat counter and SHALL NOT interact arithmetically.
REQ-005 The group length N SHALL be latched from cfg_acc_num when the first beat of a group is accepted (counter == 0). Changes to cfg_acc_num mid-group SHALL take effect at the next group.
REQ-006 N == 0 and N == 1 SHALL both mean every accepted beat is a complete group.
REQ-007 On a non-final accepted beat: acc[k] <= acc[k] + ext(idata[k]); counter increments.
REQ-008 On the final accepted beat (counter == N-1):
- odata[k] <= acc[k] + ext(idata[k]), so the final beat is included.
- acc[k] <= 0 and counter <= 0.
- odata_valid <= 1 on the next cycle (latency 1 from the final beat).
REQ-009 odata_valid SHALL clear on an edge where odata_valid && odata_ready, unless a new result is loaded on that same edge, in which case it SHALL stay 1 and odata SHALL update.
REQ-010 idata_ready SHALL be 0 when cfg_clr == 1, or when the next beat would be final and odata_valid && !odata_ready. Otherwise it SHALL be 1, so non-final beats never stall on output backpressure.
REQ-011 odata SHALL remain stable while odata_valid && !odata_ready.
REQ-012 cfg_clr == 1 SHALL zero all accumulators and the counter on that edge, accept no beat, and leave odata and odata_valid untouched.
REQ-013 Without saturation, addition SHALL wrap modulo 2^ODATA_WIDTH.

Reset
REQ-014 Assertion of rstn low SHALL immediately zero all accumulators, the counter, latched N, odata and odata_valid, including mid-group or with a result pending. The partial group is discarded.
REQ-015 While rstn is low, idata_ready SHALL be 0. After deassertion, the first accepted beat SHALL start a new group.

Configuration
REQ-016 Macro CORE_ACC_SAT_EN:
- Defined: every per-lane addition (REQ-007, REQ-008) SHALL clamp to [-2^(ODATA_WIDTH-1), 2^(ODATA_WIDTH-1)-1].
- Undefined: REQ-013 wrap behaviour applies and no clamp logic SHALL be synthesised.

Verification
REQ-017 NUM_CH=4, cfg_acc_num=3, beats lane0 = 1,2,3 and lane3 = -5,-5,-5, odata_ready=1 -> one odata_valid pulse the cycle after beat 3, lane0 = 6, lane3 = -15.
REQ-018 cfg_acc_num=0, 4 consecutive beats 7,8,9,10 -> 4 back-to-back results 7,8,9,10, idata_ready constantly 1.
REQ-019 cfg_acc_num=2, odata_ready=0 after the first result -> idata_ready drops only when the second group's final beat is offered; odata holds the first result; raising odata_ready accepts the stalled beat on that edge.
REQ-020 cfg_acc_num=4, cfg_clr pulsed after 2 beats of 100 -> next 4 beats of 1 yield 4 (not 204); the prior pending odata is unchanged.
REQ-021 ODATA_WIDTH=8, IDATA_WIDTH=8, cfg_acc_num=2, beats 100,100 -> 127 with CORE_ACC_SAT_EN, -56 without.
REQ-022 rstn pulsed low mid-group (after 1 of 3 beats) and while odata_valid=1 -> odata_valid and odata go to 0 asynchronously; the next 3 beats of 1 yield 3.

Source files
------------

// File: rtl/core_acc_mc_if.sv
// rtl/core_acc_mc_if.sv - input-beat and result streams of the multi-lane accumulator
//
// Signals:
//   idata        NUM_CH*IDATA_WIDTH  packed lane inputs (lane k at [k*IDATA_WIDTH +: IDATA_WIDTH])
//   idata_valid  1                   input beat offered
//   idata_ready  1                   input beat can be accepted
//   odata        NUM_CH*ODATA_WIDTH  packed lane results (same packing rule)
//   odata_valid  1                   result held
//   odata_ready  1                   downstream accepts result
// Modports: master = beat source / result sink, slave = accumulator.
interface core_acc_mc_if #(
    parameter int NUM_CH      = 4,
    parameter int IDATA_WIDTH = 24,
    parameter int ODATA_WIDTH = 32
) ();
    logic [NUM_CH*IDATA_WIDTH-1:0] idata;
    logic                          idata_valid;
    logic                          idata_ready;
    logic [NUM_CH*ODATA_WIDTH-1:0] odata;
    logic                          odata_valid;
    logic                          odata_ready;

    modport master (
        output idata, idata_valid, odata_ready,
        input  idata_ready, odata, odata_valid
    );

    modport slave (
        input  idata, idata_valid, odata_ready,
        output idata_ready, odata, odata_valid
    );
endinterface

// File: rtl/core_acc_mc.sv
// rtl/core_acc_mc.sv - multi-lane signed accumulator emitting one result per group of beats
//
// Ports:
//   clk          clock, all state on rising edge
//   rstn         asynchronous active-low reset
//   cfg_acc_num  beats per group (0 and 1 both mean one beat per group), latched on a group's first beat
//   cfg_clr      synchronous flush of partial sums and beat counter; result register untouched
//   bus          core_acc_mc_if.slave: idata/idata_valid/idata_ready in, odata/odata_valid/odata_ready out
// Configuration macro:
//   CORE_ACC_SAT_EN  defined: each per-lane addition clamps to the signed ODATA_WIDTH range;
//                    undefined: additions wrap modulo 2^ODATA_WIDTH.
module core_acc_mc #(
    parameter int NUM_CH               = 4,
    parameter int IDATA_WIDTH          = 24,
    parameter int ODATA_WIDTH          = 32,
    parameter int CDATA_ACCU_NUM_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [CDATA_ACCU_NUM_WIDTH-1:0] cfg_acc_num,
    input  logic                            cfg_clr,
    core_acc_mc_if.slave                    bus
);

    localparam logic [CDATA_ACCU_NUM_WIDTH-1:0] CNT_ONE = 1;

    logic signed [ODATA_WIDTH-1:0]    acc [NUM_CH];
    logic signed [ODATA_WIDTH-1:0]    sum [NUM_CH];
    logic [CDATA_ACCU_NUM_WIDTH-1:0]  cnt;
    logic [CDATA_ACCU_NUM_WIDTH-1:0]  n_lat;
    logic [CDATA_ACCU_NUM_WIDTH-1:0]  grp_n;
    logic                             final_beat;
    logic                             accept;
    logic [NUM_CH*ODATA_WIDTH-1:0]    odata_q;
    logic                             odata_valid_q;

    // Sign-extend the lane input and add it to the lane accumulator.
    function automatic logic signed [ODATA_WIDTH-1:0] lane_add(
        input logic signed [ODATA_WIDTH-1:0] a,
        input logic signed [IDATA_WIDTH-1:0] b
    );
`ifdef CORE_ACC_SAT_EN
        logic signed [ODATA_WIDTH:0] wide;
        wide = (ODATA_WIDTH+1)'(a) + (ODATA_WIDTH+1)'(b);
        // One guard bit disagreeing with the result sign flags overflow.
        if (wide[ODATA_WIDTH] != wide[ODATA_WIDTH-1]) begin
            if (wide[ODATA_WIDTH]) begin
                lane_add = {1'b1, {(ODATA_WIDTH-1){1'b0}}};
            end else begin
                lane_add = {1'b0, {(ODATA_WIDTH-1){1'b1}}};
            end
        end else begin
            lane_add = wide[ODATA_WIDTH-1:0];
        end
`else
        lane_add = a + ODATA_WIDTH'(b);
`endif
    endfunction

    // The live config governs the first beat of a group; later beats use the latched length.
    assign grp_n      = (cnt == '0) ? cfg_acc_num : n_lat;
    assign final_beat = (grp_n <= CNT_ONE) || (cnt == grp_n - CNT_ONE);

    // Only a final beat needs the result register, so only it stalls on backpressure.
    assign bus.idata_ready = rstn & ~cfg_clr & ~(final_beat & odata_valid_q & ~bus.odata_ready);
    assign accept          = bus.idata_valid & bus.idata_ready;

    assign bus.odata       = odata_q;
    assign bus.odata_valid = odata_valid_q;

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            sum[k] = '0;
            sum[k] = lane_add(acc[k], bus.idata[k*IDATA_WIDTH +: IDATA_WIDTH]);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < NUM_CH; k++) begin
                acc[k] <= '0;
            end
            cnt           <= '0;
            n_lat         <= '0;
            odata_q       <= '0;
            odata_valid_q <= 1'b0;
        end else begin
            // A load later in this block overrides the handshake clear.
            if (odata_valid_q && bus.odata_ready) begin
                odata_valid_q <= 1'b0;
            end
            if (cfg_clr) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    acc[k] <= '0;
                end
                cnt <= '0;
            end else if (accept) begin
                if (cnt == '0) begin
                    n_lat <= cfg_acc_num;
                end
                if (final_beat) begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        odata_q[k*ODATA_WIDTH +: ODATA_WIDTH] <= sum[k];
                        acc[k] <= '0;
                    end
                    cnt           <= '0;
                    odata_valid_q <= 1'b1;
                end else begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        acc[k] <= sum[k];
                    end
                    cnt <= cnt + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_core_acc_mc.sv
// tb/tb_core_acc_mc.sv - self-checking bench for core_acc_mc with a group-level reference model
module tb_core_acc_mc;
    localparam int NCH = 4;
    localparam int IW  = 24;
    localparam int OW  = 32;
    localparam int CW  = 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic [CW-1:0] cfg_acc_num;
    logic          cfg_clr;
    logic [CW-1:0] cfg_b;
    logic          clr_b;

    always #5 clk = ~clk;

    core_acc_mc_if #(.NUM_CH(NCH), .IDATA_WIDTH(IW), .ODATA_WIDTH(OW)) bus_a ();
    core_acc_mc_if #(.NUM_CH(1), .IDATA_WIDTH(8), .ODATA_WIDTH(8)) bus_b ();

    core_acc_mc #(.NUM_CH(NCH), .IDATA_WIDTH(IW), .ODATA_WIDTH(OW), .CDATA_ACCU_NUM_WIDTH(CW)) dut_a (
        .clk(clk), .rstn(rstn), .cfg_acc_num(cfg_acc_num), .cfg_clr(cfg_clr), .bus(bus_a)
    );

    core_acc_mc #(.NUM_CH(1), .IDATA_WIDTH(8), .ODATA_WIDTH(8), .CDATA_ACCU_NUM_WIDTH(CW)) dut_b (
        .clk(clk), .rstn(rstn), .cfg_acc_num(cfg_b), .cfg_clr(clr_b), .bus(bus_b)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: one running sum per lane, a beat count within the group, the group length.
    longint m_acc [NCH];
    longint m_out [NCH];
    int     m_cnt;
    int     m_n;
    bit     m_valid;
    int     lane_v [NCH];

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint fold(input longint x);
        longint lim;
        longint r;
        lim = longint'(1) << (OW - 1);
`ifdef CORE_ACC_SAT_EN
        if (x > lim - 1) r = lim - 1;
        else if (x < -lim) r = -lim;
        else r = x;
`else
        r = x % (2 * lim);
        if (r >= lim) r = r - 2 * lim;
        if (r < -lim) r = r + 2 * lim;
`endif
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) begin
            m_acc[k] = 0;
            m_out[k] = 0;
        end
        m_cnt   = 0;
        m_n     = 1;
        m_valid = 0;
    endtask

    task automatic check_out(input string tag);
        logic signed [OW-1:0] o;
        chk({tag, ".odata_valid"}, bus_a.odata_valid, m_valid);
        if (m_valid) begin
            for (int k = 0; k < NCH; k++) begin
                o = bus_a.odata[k*OW +: OW];
                chk($sformatf("%s.lane%0d", tag, k), o, m_out[k]);
            end
        end
    endtask

    // One clock of stimulus on DUT A; entered and left just after a falling edge.
    task automatic cycle(input string tag, input bit v, input bit ordy, input bit clr);
        int  n_eff;
        bit  exp_ready;
        bit  loaded;
        bus_a.idata_valid = v;
        bus_a.odata_ready = ordy;
        cfg_clr           = clr;
        for (int k = 0; k < NCH; k++) bus_a.idata[k*IW +: IW] = lane_v[k][IW-1:0];
        #1;
        n_eff = (m_cnt == 0) ? int'(cfg_acc_num) : m_n;
        if (n_eff < 1) n_eff = 1;
        exp_ready = !clr && !((m_cnt + 1 == n_eff) && m_valid && !ordy);
        chk({tag, ".idata_ready"}, bus_a.idata_ready, exp_ready);
        @(posedge clk);
        loaded = 0;
        if (clr) begin
            for (int k = 0; k < NCH; k++) m_acc[k] = 0;
            m_cnt = 0;
        end else if (v && exp_ready) begin
            if (m_cnt == 0) m_n = n_eff;
            for (int k = 0; k < NCH; k++) m_acc[k] = fold(m_acc[k] + lane_v[k]);
            m_cnt++;
            if (m_cnt == m_n) begin
                for (int k = 0; k < NCH; k++) begin
                    m_out[k] = m_acc[k];
                    m_acc[k] = 0;
                end
                m_cnt  = 0;
                loaded = 1;
            end
        end
        if (loaded) m_valid = 1;
        else if (m_valid && ordy) m_valid = 0;
        @(negedge clk);
        check_out(tag);
    endtask

    task automatic set_lanes(input int a, input int b, input int c, input int d);
        lane_v[0] = a;
        lane_v[1] = b;
        lane_v[2] = c;
        lane_v[3] = d;
    endtask

    initial begin
        logic signed [7:0] ob;
        logic signed [OW-1:0] o;
        int r;
        rstn              = 1'b0;
        cfg_acc_num       = '0;
        cfg_clr           = 1'b0;
        cfg_b             = '0;
        clr_b             = 1'b0;
        bus_a.idata       = '0;
        bus_a.idata_valid = 1'b0;
        bus_a.odata_ready = 1'b0;
        bus_b.idata       = '0;
        bus_b.idata_valid = 1'b0;
        bus_b.odata_ready = 1'b1;
        set_lanes(0, 0, 0, 0);
        model_reset();

        // Reset state
        @(negedge clk);
        chk("reset.idata_ready", bus_a.idata_ready, 1'b0);
        chk("reset.odata_valid", bus_a.odata_valid, 1'b0);
        chk("reset.odata", bus_a.odata, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // Three-beat group, lanes independent
        cfg_acc_num = 3;
        set_lanes(1, 0, 0, -5); cycle("g3.b1", 1, 1, 0);
        set_lanes(2, 0, 0, -5); cycle("g3.b2", 1, 1, 0);
        set_lanes(3, 0, 0, -5); cycle("g3.b3", 1, 1, 0);
        o = bus_a.odata[0 +: OW];    chk("g3.lane0_const", o, 6);
        o = bus_a.odata[3*OW +: OW]; chk("g3.lane3_const", o, -15);
        cycle("g3.idle", 0, 1, 0);

        // Length 0: every beat is its own group, back to back
        cfg_acc_num = 0;
        for (int i = 7; i <= 10; i++) begin
            set_lanes(i, i, i, i);
            cycle($sformatf("n0.b%0d", i), 1, 1, 0);
            o = bus_a.odata[0 +: OW];
            chk($sformatf("n0.const%0d", i), o, i);
        end
        cycle("n0.idle", 0, 1, 0);

        // Backpressure stalls only the final beat
        cfg_acc_num = 2;
        set_lanes(1, 1, 1, 1); cycle("bp.g1b1", 1, 1, 0);
        set_lanes(2, 2, 2, 2); cycle("bp.g1b2", 1, 0, 0);
        set_lanes(4, 4, 4, 4); cycle("bp.g2b1", 1, 0, 0);
        set_lanes(5, 5, 5, 5); cycle("bp.g2b2_stall", 1, 0, 0);
        chk("bp.stall_ready", bus_a.idata_ready, 1'b0);
        o = bus_a.odata[0 +: OW]; chk("bp.hold_const", o, 3);
        cycle("bp.g2b2_stall2", 1, 0, 0);
        cycle("bp.g2b2_go", 1, 1, 0);
        o = bus_a.odata[0 +: OW]; chk("bp.g2_const", o, 9);

        // Flush mid-group while a result is pending
        cfg_acc_num = 4;
        set_lanes(100, 100, 100, 100); cycle("clr.b1", 1, 0, 0);
        cycle("clr.b2", 1, 0, 0);
        cycle("clr.pulse", 1, 0, 1);
        o = bus_a.odata[0 +: OW]; chk("clr.pending_const", o, 9);
        set_lanes(1, 1, 1, 1);
        for (int i = 0; i < 3; i++) cycle($sformatf("clr.n%0d", i), 1, 0, 0);
        cycle("clr.n3_stall", 1, 0, 0);
        cycle("clr.n3_go", 1, 1, 0);
        o = bus_a.odata[0 +: OW]; chk("clr.result_const", o, 4);
        cycle("clr.idle", 0, 1, 0);

        // Asynchronous reset mid-group with a result pending
        cfg_acc_num = 1;
        set_lanes(50, 50, 50, 50); cycle("rst.pend", 1, 0, 0);
        cfg_acc_num = 3;
        set_lanes(1, 1, 1, 1); cycle("rst.partial", 1, 0, 0);
        #2;
        rstn = 1'b0;
        #1;
        chk("rst.odata_valid", bus_a.odata_valid, 1'b0);
        chk("rst.odata", bus_a.odata, 0);
        chk("rst.idata_ready", bus_a.idata_ready, 1'b0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) cycle($sformatf("rst.after%0d", i), 1, 1, 0);
        o = bus_a.odata[0 +: OW]; chk("rst.result_const", o, 3);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            cfg_acc_num = CW'($urandom_range(0, 5));
            for (int k = 0; k < NCH; k++) begin
                r = $urandom;
                lane_v[k] = r >>> 8;
            end
            cycle($sformatf("rnd%0d", i), ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 19) == 0));
        end
        cycle("rnd.drain", 0, 1, 0);

        // Narrow instance: overflow behaviour
        cfg_b = 2;
        bus_b.idata = 8'd100;
        bus_b.idata_valid = 1'b1;
        #1;
        chk("ovf.ready1", bus_b.idata_ready, 1'b1);
        @(negedge clk);
        chk("ovf.ready2", bus_b.idata_ready, 1'b1);
        @(negedge clk);
        bus_b.idata_valid = 1'b0;
        chk("ovf.odata_valid", bus_b.odata_valid, 1'b1);
        ob = bus_b.odata;
`ifdef CORE_ACC_SAT_EN
        chk("ovf.odata", ob, 127);
`else
        chk("ovf.odata", ob, -56);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
